// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming 1-D convolution engine.
package conv_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Working width of the saturation helper; wide enough for any sum width.
  localparam int SAT_W = 64;

  // Ceiling log2, never less than 1 so it can size an index port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

  // Unsigned sample (plus a zero sign bit) times signed coefficient.
  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  // Sum of taps products; the extra clog2(taps) bits rule out overflow.
  function automatic int sum_w(input int data_w, input int coef_w, input int taps);
    return prod_w(data_w, coef_w) + clog2(taps);
  endfunction

  // Optional ReLU clamp, then signed saturation to out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] x,
    input int                      out_w,
    input logic                    relu
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (relu && x[SAT_W-1]) return '0;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/conv_add_tree.sv
// Registered reduction of N signed products into one full-width sum.
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int N     = 5,
  parameter int IN_W  = 9,
  parameter int SUM_W = IN_W + clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_vld,
  input  logic                    i_last,
  input  logic signed [IN_W-1:0]  i_prod [N],
  output logic                    o_vld,
  output logic                    o_last,
  output logic signed [SUM_W-1:0] o_sum
);

  logic signed [SUM_W-1:0] w_acc;

  // Sign-extend every product to the sum width and add them up
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N; i++) begin
      w_acc = w_acc + SUM_W'(i_prod[i]);
    end
  end

  // Sum stage control: valid and frame-end flag, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld  <= 1'b0;
      o_last <= 1'b0;
    end else if (i_en) begin
      o_vld  <= i_vld;
      o_last <= i_last;
    end
  end

  // Sum stage data: only meaningful while o_vld is set
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_sum <= w_acc;
    end
  end

endmodule

// File: rtl/conv1d_stream.sv
// Streaming 1-D convolution: sliding window x loadable signed kernel,
// 3-stage product/sum/output pipeline with ReLU and saturation, and a
// single global stall driven by the output handshake.
module conv1d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 5,
  parameter int OUT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic                       coef_wr,
  input  logic [clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       relu_en,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready
);

  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int SUM_W  = sum_w(DATA_W, COEF_W, TAPS);
  localparam int CNT_W  = clog2(TAPS);

  logic                     w_adv;
  logic                     w_accept;
  logic                     w_launch;
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;

  logic [DATA_W-1:0]        r_win  [TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic                     r_vld_p0;
  logic                     r_last_p0;

  logic signed [PROD_W-1:0] r_prod_p1 [TAPS];
  logic                     r_vld_p1;
  logic                     r_last_p1;

  logic signed [SUM_W-1:0]  w_sum_p2;
  logic                     w_vld_p2;
  logic                     w_last_p2;

  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_vld;
  logic                     r_out_last;

  // Whole pipeline moves together; it only freezes when a result is stuck
  assign w_adv    = ~r_out_vld | out_ready;
  assign in_ready = w_adv;
  assign w_accept = in_valid & w_adv;

  assign out_data  = r_out_data;
  assign out_valid = r_out_vld;
  assign out_last  = r_out_last;

  // Next-state logic: decide when an accept completes a window and launches it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    if (w_accept) begin
      case (r_state)
        FILL: begin
          if (r_cnt == CNT_W'(TAPS - 1)) begin
            w_launch    = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RUN:     w_launch = 1'b1;
        default: w_launch = 1'b0;
      endcase
      if (in_last) begin
        w_state_nxt = FILL;
        w_cnt_nxt   = '0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else if (w_adv) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Coefficient file; writes proceed even while the pipeline is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if (coef_wr) begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_addr == CNT_W'(i)) r_coef[i] <= coef_data;
      end
    end
  end

  // ---- stage p0: sliding window, newest sample enters at the top ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
    end else if (w_adv) begin
      if (w_accept) begin
        for (int i = 0; i < TAPS - 1; i++) r_win[i] <= r_win[i+1];
        r_win[TAPS-1] <= in_data;
      end
      r_vld_p0  <= w_launch;
      r_last_p0 <= w_launch & in_last;
    end
  end

  // ---- stage p1: per-tap products (control) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_last_p0;
    end
  end

  // Per-tap products: zero-extended sample times signed coefficient
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int i = 0; i < TAPS; i++) begin
        r_prod_p1[i] <= PROD_W'($signed({1'b0, r_win[i]})) * PROD_W'(r_coef[i]);
      end
    end
  end

  // ---- stage p2: registered sum of products ----
  conv_add_tree #(
    .N     (TAPS),
    .IN_W  (PROD_W),
    .SUM_W (SUM_W)
  ) u_add_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_adv),
    .i_vld  (r_vld_p1),
    .i_last (r_last_p1),
    .i_prod (r_prod_p1),
    .o_vld  (w_vld_p2),
    .o_last (w_last_p2),
    .o_sum  (w_sum_p2)
  );

  // ---- output stage: ReLU / saturate, held stable while stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else if (w_adv) begin
      r_out_vld  <= w_vld_p2;
      r_out_last <= w_last_p2;
      r_out_data <= OUT_W'(sat_relu(SAT_W'(w_sum_p2), OUT_W, relu_en));
    end
  end

endmodule

// File: tb/tb_conv1d_stream.sv
// Self-checking bench for conv1d_stream: scenario tasks plus a scoreboard
// of expected results consumed as the DUT hands them out.
module tb_conv1d_stream;

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int TAPS   = 5;
  localparam int OUT_W  = 8;

  logic                     clk;
  logic                     rst_n;
  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic                     coef_wr;
  logic [2:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     relu_en;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready;

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic                    last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  conv1d_stream #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .relu_en   (relu_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every handed-out result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got data=%0d last=%0b, expected no output", out_data, out_last);
      end else begin
        mon_e = sb.pop_front();
        n_checks++;
        if (out_data !== mon_e.data) begin
          n_errors++;
          $display("FAIL out_data: got %0d, expected %0d", out_data, mon_e.data);
        end
        n_checks++;
        if (out_last !== mon_e.last) begin
          n_errors++;
          $display("FAIL out_last: got %0b, expected %0b (data %0d)", out_last, mon_e.last, mon_e.data);
        end
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input int d, input bit l);
    exp_t e;
    e.data = d[OUT_W-1:0];
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic write_coef(input int a, input int v);
    coef_wr   = 1'b1;
    coef_addr = a[2:0];
    coef_data = v[COEF_W-1:0];
    @(posedge clk); #1;
    coef_wr   = 1'b0;
  endtask

  task automatic load_uniform(input int v);
    for (int i = 0; i < TAPS; i++) write_coef(i, v);
  endtask

  // Offer one sample and return just after the edge that accepted it
  task automatic send(input int d, input bit l);
    int w;
    w        = 0;
    in_data  = d[DATA_W-1:0];
    in_valid = 1'b1;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, w);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame5(input int a, input int b, input int c, input int d, input int e);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
    send(e, 1'b1);
    idle();
  endtask

  // Wait (bounded) for every expectation to be consumed
  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    coef_wr   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
    n_checks++;
    if (out_data !== 8'sd0) begin n_errors++; $display("FAIL reset_out_data: got %0d, expected 0", out_data); end
    n_checks++;
    if (out_last !== 1'b0) begin n_errors++; $display("FAIL reset_out_last: got %0b, expected 0", out_last); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_uniform(1);
    push(42, 1'b0);
    push(32, 1'b1);
    send(14, 1'b0);
    send(7, 1'b0);
    send(10, 1'b0);
    send(9, 1'b0);
    send(2, 1'b0);
    send(4, 1'b1);
    idle();
    // the window completed by sample 2 must appear exactly 3 edges later
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL latency_edge1: out_valid=%0b, expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL latency_edge2: out_valid=%0b, expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL latency_edge3: out_valid=%0b, expected 1", out_valid); end
    drain("basic");
  endtask

  task automatic test_kernel();
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    push(15, 1'b1);
    send_frame5(1, 1, 1, 1, 1);
    push(5, 1'b1);
    send_frame5(0, 0, 0, 0, 1);
    drain("kernel_newest");
    // out-of-range addresses must not disturb the kernel
    write_coef(5, -8);
    write_coef(6, -8);
    write_coef(7, -8);
    push(15, 1'b1);
    send_frame5(1, 1, 1, 1, 1);
    push(1, 1'b1);
    send_frame5(1, 0, 0, 0, 0);
    drain("kernel_addr_ignore");
  endtask

  task automatic test_saturation();
    load_uniform(7);
    relu_en = 1'b0;
    push(127, 1'b1);
    send_frame5(15, 15, 15, 15, 15);
    drain("sat_pos");
    relu_en = 1'b1;
    push(70, 1'b1);
    send_frame5(2, 2, 2, 2, 2);
    drain("relu_pass");
    load_uniform(-8);
    relu_en = 1'b0;
    push(-128, 1'b1);
    send_frame5(15, 15, 15, 15, 15);
    push(-8, 1'b1);
    send_frame5(1, 0, 0, 0, 0);
    drain("sat_neg");
    relu_en = 1'b1;
    push(0, 1'b1);
    send_frame5(15, 15, 15, 15, 15);
    drain("relu_clamp");
    relu_en = 1'b0;
  endtask

  task automatic test_stall();
    int                      w;
    logic signed [OUT_W-1:0] held_data;
    logic                    held_last;
    load_uniform(1);
    push(15, 1'b0);
    push(20, 1'b0);
    push(25, 1'b0);
    push(30, 1'b0);
    push(35, 1'b1);
    fork
      begin
        for (int s = 1; s <= 8; s++) send(s, 1'b0);
        send(9, 1'b1);
        idle();
      end
      begin
        w = 0;
        while (!out_valid && w < 100) begin
          @(posedge clk); #1;
          w++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_wait: out_valid=%0b, expected 1", out_valid); end
        out_ready = 1'b0;
        held_data = out_data;
        held_last = out_last;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          n_checks++;
          if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready[%0d]: got %0b, expected 0", c, in_ready); end
          n_checks++;
          if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_out_valid[%0d]: got %0b, expected 1", c, out_valid); end
          n_checks++;
          if (out_data !== held_data || out_last !== held_last) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: got %0d/%0b, expected %0d/%0b", c, out_data, out_last, held_data, held_last);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("stall");
  endtask

  task automatic test_short_frame();
    int seen;
    load_uniform(1);
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b1);
    idle();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_errors++; $display("FAIL short_frame_quiet: %0d valid cycles, expected 0", seen); end
    @(posedge clk); #1;
    push(5, 1'b1);
    send_frame5(1, 1, 1, 1, 1);
    drain("short_then_single");
  endtask

  task automatic test_back_to_back();
    load_uniform(1);
    push(15, 1'b0);
    push(20, 1'b1);
    push(10, 1'b1);
    for (int s = 1; s <= 5; s++) send(s, 1'b0);
    send(6, 1'b1);
    for (int s = 0; s < 4; s++) send(2, 1'b0);
    send(2, 1'b1);
    idle();
    drain("back_to_back");
  endtask

  task automatic test_reset_midframe();
    load_uniform(1);
    for (int s = 1; s <= 8; s++) send(s, 1'b0);
    idle();
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL midreset_inflight: out_valid=%0b, expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_async_valid: got %0b, expected 0", out_valid); end
    n_checks++;
    if (out_data !== 8'sd0) begin n_errors++; $display("FAIL midreset_async_data: got %0d, expected 0", out_data); end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_in_ready: got %0b, expected 1", in_ready); end
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    push(0, 1'b1);
    send_frame5(3, 5, 7, 9, 11);
    drain("midreset_zero_coef");
    load_uniform(1);
    push(35, 1'b1);
    send_frame5(3, 5, 7, 9, 11);
    drain("midreset_reload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_kernel();
    test_saturation();
    test_stall();
    test_short_frame();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
